// File: rtl/axi_fifo_sync_fwft_if.sv
// ---------------------------------------------------------------------------
// axi_fifo_sync_fwft_if
//   Bundles the push/pop handshake and the status outputs of the FWFT FIFO
//   that sits between the AXI-Lite FIFO bridge and the datapath.
//
//   Signals
//     wr_data       write word
//     wr_en         push request
//     full          count == DEPTH
//     almost_full   count >= ALMOST_FULL_LEVEL
//     rd_data       head word (first-word-fall-through), 0 while empty
//     rd_en         pop request
//     empty         count == 0
//     almost_empty  count <= ALMOST_EMPTY_LEVEL
//     count         occupancy, 0..DEPTH
//     overflow      sticky, push attempted while full
//     underflow     sticky, pop attempted while empty
//
//   Modports
//     slave   the FIFO itself
//     master  the bridge / producer-consumer side
// ---------------------------------------------------------------------------
interface axi_fifo_sync_fwft_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4
);
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_en;
   logic                  full;
   logic                  almost_full;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_en;
   logic                  empty;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   count;
   logic                  overflow;
   logic                  underflow;

   modport slave (
      input  wr_data, wr_en, rd_en,
      output full, almost_full, rd_data, empty, almost_empty,
             count, overflow, underflow
   );

   modport master (
      output wr_data, wr_en, rd_en,
      input  full, almost_full, rd_data, empty, almost_empty,
             count, overflow, underflow
   );
endinterface

// File: rtl/axi_fifo_sync_fwft.sv
// ---------------------------------------------------------------------------
// axi_fifo_sync_fwft
//   Single-clock first-word-fall-through FIFO. The head word is presented on
//   rd_data whenever the FIFO is not empty, so the consumer samples it in the
//   same cycle it asserts rd_en. Status flags are decoded from the registered
//   occupancy only, so none of them depends combinationally on wr_en/rd_en.
//
//   Ports
//     aclk      clock, all state updates on the rising edge
//     aresetn   synchronous active-low reset (pointers, count, error flags)
//     fifo      axi_fifo_sync_fwft_if.slave: push/pop handshake and status
//
//   Parameters
//     DATA_WIDTH          word width
//     ADDR_WIDTH          log2 of depth
//     ALMOST_FULL_LEVEL   almost_full when count >= this (1..DEPTH)
//     ALMOST_EMPTY_LEVEL  almost_empty when count <= this (0..DEPTH-1)
// ---------------------------------------------------------------------------
module axi_fifo_sync_fwft #(
   parameter int DATA_WIDTH         = 32,
   parameter int ADDR_WIDTH         = 4,
   parameter int ALMOST_FULL_LEVEL  = 14,
   parameter int ALMOST_EMPTY_LEVEL = 2
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   axi_fifo_sync_fwft_if.slave   fifo
);

   localparam int                  DEPTH    = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH + 1)'(ALMOST_FULL_LEVEL);
   localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_LEVEL);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;

   logic full_s;
   logic empty_s;
   logic push;
   logic pop;

   // Full/empty come from the pre-edge count, so a simultaneous push+pop on
   // a full FIFO rejects the push (no pass-through) and on an empty FIFO
   // rejects the pop (the new word is not yet readable).
   assign full_s  = (count_q == DEPTH_C);
   assign empty_s = (count_q == '0);
   assign push    = fifo.wr_en && !full_s;
   assign pop     = fifo.rd_en && !empty_s;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q  | (fifo.wr_en & full_s);
      underflow_d = underflow_q | (fifo.rd_en & empty_s);

      // Pointers are exactly ADDR_WIDTH bits, so DEPTH-1 wraps to 0.
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage carries no reset; a push coinciding with reset is dropped so the
   // array is only ever written by accepted pushes.
   always_ff @(posedge aclk) begin
      if (aresetn && push) begin
         mem_q[wr_ptr_q] <= fifo.wr_data;
      end
   end

   // FWFT head: a word written at edge N is at rd_ptr and visible after N.
   assign fifo.rd_data      = empty_s ? '0 : mem_q[rd_ptr_q];
   assign fifo.full         = full_s;
   assign fifo.empty        = empty_s;
   assign fifo.almost_full  = (count_q >= AFULL_C);
   assign fifo.almost_empty = (count_q <= AEMPTY_C);
   assign fifo.count        = count_q;
   assign fifo.overflow     = overflow_q;
   assign fifo.underflow    = underflow_q;

endmodule
